// File: rtl/data_mem_port_if.sv
// Processor-side bus of the data memory port: request/command in, load data and status out.
interface data_mem_port_if #(
    parameter int ADDR_W = 10
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic [15:0]       rdata;
    logic              mem_write_en;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, mem_write_en, busy, done, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, mem_write_en, busy, done, err
    );
endinterface

// File: rtl/data_mem_port.sv
// Single-port 16-bit data memory with a load/store FSM; loads respond READ_LAT wait cycles
// after acceptance, stores complete in one cycle. Array contents survive reset.
module data_mem_port #(
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    data_mem_port_if.slave  bus
);
    localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]       LAT_LAST = 4'(READ_LAT - 1);
    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_RESP = 2'd2,
        WR      = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              arr_we;
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    logic [15:0] mem [DEPTH];

    assign in_range  = {1'b0, addr_q} < DEPTH_L;
    assign idx       = addr_q[IDX_W-1:0];
    assign bus.rdata = rdata_q;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        rdata_d          = rdata_q;
        arr_we           = 1'b0;
        bus.busy         = 1'b1;
        bus.done         = 1'b0;
        bus.err          = 1'b0;
        bus.mem_write_en = 1'b0;

        unique case (state_q)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.req) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    cnt_d   = '0;
                    state_d = bus.we ? WR : RD_WAIT;
                end
            end
            RD_WAIT: begin
                // rdata is captured on entry to RD_RESP so it is valid for the whole response cycle
                if (cnt_q == LAT_LAST) begin
                    cnt_d   = '0;
                    state_d = RD_RESP;
                    if (in_range) begin
                        rdata_d = mem[idx];
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RD_RESP: begin
                bus.done         = 1'b1;
                bus.err          = ~in_range;
                bus.mem_write_en = in_range;
                state_d          = IDLE;
            end
            WR: begin
                bus.done = 1'b1;
                bus.err  = ~in_range;
                arr_we   = in_range;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // No reset here: contents persist, and reset forces IDLE so a pending WR never commits
    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem[idx] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_data_mem_port.sv
// Bench for data_mem_port: four builds (default, READ_LAT=1, READ_LAT=5, ADDR_W=11) share one
// stimulus; a transaction-countdown model predicts every output each cycle.
module tb_data_mem_port;
    localparam int NI = 4;
    localparam int LAT_T   [NI] = '{2, 1, 5, 2};
    localparam int AW_T    [NI] = '{10, 10, 10, 11};
    localparam int MWE_CYC [NI] = '{3, 2, 6, 3};

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [10:0] addr  = '0;
    logic [15:0] wdata = '0;

    logic [NI-1:0]       busy_v, done_v, err_v, mwe_v;
    logic [NI-1:0][15:0] rdata_v;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        data_mem_port_if #(.ADDR_W(AW_T[g])) ifc ();
        assign ifc.req   = req;
        assign ifc.we    = we;
        assign ifc.addr  = addr[AW_T[g]-1:0];
        assign ifc.wdata = wdata;
        assign busy_v[g]  = ifc.busy;
        assign done_v[g]  = ifc.done;
        assign err_v[g]   = ifc.err;
        assign mwe_v[g]   = ifc.mem_write_en;
        assign rdata_v[g] = ifc.rdata;

        data_mem_port #(
            .DEPTH    (1024),
            .ADDR_W   (AW_T[g]),
            .READ_LAT (LAT_T[g])
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ifc)
        );
    end

    // Model: each accepted request occupies a known number of cycles; its last cycle responds.
    int          rem    [NI] = '{default: 0};
    bit          m_we   [NI] = '{default: 1'b0};
    int          m_addr [NI] = '{default: 0};
    logic [15:0] m_wd   [NI] = '{default: '0};
    logic [15:0] m_rd   [NI] = '{default: '0};
    logic [15:0] mm     [NI][1024];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < NI; g++) begin
                rem[g]  = 0;
                m_rd[g] = '0;
            end
        end else begin
            for (int g = 0; g < NI; g++) begin
                if (rem[g] > 0) begin
                    if (rem[g] == 1 && m_we[g] && m_addr[g] < 1024)
                        mm[g][m_addr[g][9:0]] = m_wd[g];
                    rem[g] = rem[g] - 1;
                    if (rem[g] == 1 && !m_we[g] && m_addr[g] < 1024)
                        m_rd[g] = mm[g][m_addr[g][9:0]];
                end else if (req) begin
                    m_we[g]   = we;
                    m_addr[g] = int'(addr) % (1 << AW_T[g]);
                    m_wd[g]   = wdata;
                    rem[g]    = we ? 1 : LAT_T[g] + 1;
                end
            end
        end
    end

    int errors = 0;
    int checks = 0;

    int          d_cyc     [NI];
    int          m_cyc     [NI];
    int          e_cyc     [NI];
    logic [15:0] rd_at_mwe [NI];

    task automatic chk(input string name, input int g, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", name, g, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            for (int g = 0; g < NI; g++) begin
                bit fin, oor;
                fin = (rem[g] == 1);
                oor = (m_addr[g] >= 1024);
                chk("busy",  g, 16'(busy_v[g]), 16'(rem[g] > 0));
                chk("done",  g, 16'(done_v[g]), 16'(fin));
                chk("err",   g, 16'(err_v[g]),  16'(fin && oor));
                chk("mwe",   g, 16'(mwe_v[g]),  16'(fin && !m_we[g] && !oor));
                chk("rdata", g, rdata_v[g], m_rd[g]);
            end
        end
    endtask

    task automatic check_zero(input string name);
        for (int g = 0; g < NI; g++) begin
            chk({name, "_busy"},  g, 16'(busy_v[g]), 16'h0);
            chk({name, "_done"},  g, 16'(done_v[g]), 16'h0);
            chk({name, "_err"},   g, 16'(err_v[g]),  16'h0);
            chk({name, "_mwe"},   g, 16'(mwe_v[g]),  16'h0);
            chk({name, "_rdata"}, g, rdata_v[g], 16'h0000);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            if (busy_v == '0) return;
            tick();
        end
        chk("idle_timeout", 0, 16'(busy_v), 16'h0);
    endtask

    // One request, pulsed for a single edge; records response cycles relative to acceptance.
    task automatic run_op(input logic w, input logic [10:0] a, input logic [15:0] d, input bit scramble);
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int g = 0; g < NI; g++) begin
            d_cyc[g] = 0; m_cyc[g] = 0; e_cyc[g] = 0; rd_at_mwe[g] = '0;
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) req = 1'b0;
            if (scramble) begin
                addr  = 11'($urandom_range(0, 2047));
                wdata = 16'($urandom);
            end
            for (int g = 0; g < NI; g++) begin
                if (done_v[g] && d_cyc[g] == 0) d_cyc[g] = k;
                if (err_v[g] && e_cyc[g] == 0)  e_cyc[g] = k;
                if (mwe_v[g] && m_cyc[g] == 0) begin
                    m_cyc[g]     = k;
                    rd_at_mwe[g] = rdata_v[g];
                end
            end
            if (busy_v == '0) return;
        end
        chk("op_timeout", 0, 16'(busy_v), 16'h0);
    endtask

    task automatic held_seq();
        int op    = 0;
        int gap   = 1;
        int dones = 0;
        req = 1'b1; we = 1'b1; addr = 11'd0; wdata = 16'h0200;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (done_v[0]) dones++;
            if (mwe_v[0]) chk("held_rd", 0, rdata_v[0], 16'h0200 + 16'(op / 2));
            if (busy_v[0]) begin
                if (gap != 0) begin
                    chk("held_gap", 0, 16'(gap), 16'd1);
                    gap = 0;
                end
            end else begin
                gap++;
                op++;
                if (op >= 8) break;
                we    = (op % 2 == 0);
                addr  = 11'(op / 2);
                wdata = 16'h0200 + 16'(op / 2);
            end
        end
        req = 1'b0;
        chk("held_done_cnt", 0, 16'(dones), 16'd8);
        wait_idle();
    endtask

    initial begin
        #2;
        check_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // First request at the first edge after reset release; stores finish in cycle 1
        run_op(1'b1, 11'd5, 16'h1111, 1'b0);
        for (int g = 0; g < NI; g++) chk("first_st_done_cyc", g, 16'(d_cyc[g]), 16'd1);
        for (int i = 0; i < 4; i++) run_op(1'b1, 11'(i), 16'h0100 + 16'(i), 1'b0);
        run_op(1'b1, 11'd7,    16'h7777, 1'b0);
        run_op(1'b1, 11'd1023, 16'h00FF, 1'b0);

        run_op(1'b1, 11'd10, 16'hA5C3, 1'b0);
        for (int g = 0; g < NI; g++) chk("st_done_cyc", g, 16'(d_cyc[g]), 16'd1);
        run_op(1'b0, 11'd10, 16'h0000, 1'b0);
        for (int g = 0; g < NI; g++) begin
            chk("ld_mwe_cyc",  g, 16'(m_cyc[g]), 16'(MWE_CYC[g]));
            chk("ld_done_cyc", g, 16'(d_cyc[g]), 16'(MWE_CYC[g]));
            chk("ld_rdata",    g, rd_at_mwe[g], 16'hA5C3);
        end

        run_op(1'b0, 11'd1023, 16'h0000, 1'b0);
        for (int g = 0; g < NI; g++) chk("ld1023_rdata", g, rd_at_mwe[g], 16'h00FF);
        run_op(1'b0, 11'd1024, 16'h0000, 1'b0);
        chk("oor_err_cyc",  3, 16'(e_cyc[3]), 16'd3);
        chk("oor_done_cyc", 3, 16'(d_cyc[3]), 16'd3);
        chk("oor_mwe_cyc",  3, 16'(m_cyc[3]), 16'd0);
        chk("oor_rdata",    3, rdata_v[3], 16'h00FF);

        run_op(1'b0, 11'd7, 16'h0000, 1'b1);
        for (int g = 0; g < NI; g++) chk("scramble_rdata", g, rd_at_mwe[g], 16'h7777);
        addr = 11'd0;

        held_seq();

        // Reset during RD_WAIT of a load
        req = 1'b1; we = 1'b0; addr = 11'd7;
        tick();
        req = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_zero("rst_ld");
        tick();
        rst_n = 1'b1;
        tick();

        // Reset during WR of a store that must not land
        req = 1'b1; we = 1'b1; addr = 11'd5; wdata = 16'h2222;
        tick();
        req = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_zero("rst_st");
        tick();
        rst_n = 1'b1;
        tick();
        run_op(1'b0, 11'd5, 16'h0000, 1'b0);
        for (int g = 0; g < NI; g++) chk("after_rst_rdata", g, rd_at_mwe[g], 16'h1111);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
